psa_accum: RTL
==============

# psa_accum

Sequential nibble-lane accumulator for the EX stage. Accepts a burst of 16-bit operands over a valid/ready handshake, folds each into a running accumulator via `psa_16bit`, and presents the final accumulated value with a sticky lane-overflow flag. It sits directly upstream of `psa_16bit`, driving its `a`/`b` inputs, and directly downstream of it, registering `sum`/`error` every accepted beat.

## Interface
- `MAX_LEN`, default 8: maximum beats per burst; a burst auto-terminates on beat `MAX_LEN`.
- `CNT_W`, default 4: beat-counter width; equals `$clog2(MAX_LEN+1)`.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `in_valid`  in  1  operand beat offered.
- `in_ready`  out  1  block can accept a beat this cycle.
- `in_data`  in  16  operand: four 4-bit signed lanes, lane 0 = [3:0].
- `in_last`  in  1  final beat of the burst; qualified by `in_valid`.
- `out_valid`  out  1  result held and valid.
- `out_ready`  in  1  consumer takes the result.
- `out_sum`  out  16  accumulated lane-wise value.
- `out_error`  out  1  sticky: at least one lane overflow occurred in the burst.
- `out_first_err`  out  CNT_W  0-based index of the first beat that overflowed; 0 when `out_error`=0.
- `out_count`  out  CNT_W  number of beats accepted in the burst.

## Operation
- **Lane arithmetic:** matches `psa_16bit` exactly.
  - Four independent 4-bit adds with no carry between lanes; results wrap.
  - A lane overflows when both addends have the same sign and the result sign differs.
  - `error` is the OR of all four lane overflows.
- **FSM states:** IDLE, ACCUM, HOLD.
- **IDLE:** `in_ready`=1, `out_valid`=0.
  - On `in_valid`: acc <= `in_data` (an add with 0 never overflows), err <= 0, first_err <= 0, cnt <= 1.
  - Next state is HOLD if `in_last` or `MAX_LEN`=1; otherwise ACCUM.
- **ACCUM:** `in_ready`=1. On `in_valid`:
  - acc <= psa.sum(acc, `in_data`) and cnt <= cnt+1.
  - If psa.error and !err: err <= 1 and first_err <= cnt (the 0-based index of this beat).
  - Go to HOLD if `in_last` or cnt+1 == `MAX_LEN`; otherwise stay in ACCUM.
  - No `in_valid`: hold all state.
- **HOLD:** `in_ready`=0, `out_valid`=1.
  - Outputs reflect the registers and stay stable while `out_ready`=0.
  - On `out_ready`: go to IDLE. No new beat is accepted in the same cycle.
- **Output drive:** `out_*` are driven straight from registers. In IDLE and ACCUM they show in-progress values, but are only meaningful when `out_valid`=1.
- **`in_last` qualification:** ignored unless `in_valid` is high and the beat is accepted.

## Timing
- **Reset** (`rst_n`=0 at a rising edge):
  - State returns to IDLE.
  - acc, err, first_err and cnt clear to 0.
  - Resulting outputs: `in_ready`=1, `out_valid`=0, `out_sum`=0, `out_error`=0, `out_first_err`=0, `out_count`=0.
  - Reset mid-burst or in HOLD discards the burst with no output.
- **Latency:** `out_valid` rises the cycle after the terminating beat is accepted. Throughput is one beat per cycle.
- **Turnaround:** the minimum burst-to-burst gap is one cycle, since HOLD never accepts input.
- **`psa_16bit` connection:** combinational within the cycle; `a`=acc, `b`=`in_data`. The result is registered only on an accepted beat.
- **Auto-terminate:** on beat `MAX_LEN`, HOLD is entered regardless of `in_last`. A simultaneous `in_last` has no additional effect.

## Structure
- **Shared package:** state enum (IDLE/ACCUM/HOLD) and a `PSA_LANES`=4 / `LANE_W`=4 constant pair in the EX-stage package.
- **Sub-module:** one instance of `psa_16bit` (`iPSA`); no other sub-modules.
- **Size:** roughly 150 lines of RTL.

## Test plan
- **Five-beat burst with overflow:** beats 0x1234, 0x4321, 0x1111, 0x1111, 0x1111 (last on the 5th).
  - Required: `out_sum`=0x8888, `out_error`=1, `out_first_err`=4, `out_count`=5.
  - `out_valid` rises one cycle after the 5th beat is accepted.
- **No signed overflow:** 0xFFFF then 0x0001 with last.
  - Required: `out_sum`=0xFFF0, `out_error`=0, `out_count`=2.
- **Single beat:** 0x9ABC with last accepted in IDLE.
  - Required: next cycle `out_sum`=0x9ABC, `out_error`=0, `out_count`=1.
- **Auto-terminate:** eight beats of 0x1111, `in_last` never set.
  - Required: HOLD after the 8th beat, `out_sum`=0x8888, `out_error`=1, `out_first_err`=7, `out_count`=8.
  - `in_ready`=0 while in HOLD.
- **Backpressure and idle gaps:** hold `out_ready`=0 for 3 cycles in HOLD.
  - Required: outputs stable and `in_ready`=0 throughout; IDLE the cycle after `out_ready`=1.
  - Gaps in `in_valid` during ACCUM leave acc/cnt unchanged.
- **Reset mid-burst:** assert `rst_n`=0 after 2 of 4 beats.
  - Required: next cycle all outputs at reset values.
  - A new burst of 0x0003 with last yields `out_sum`=0x0003, `out_count`=1.

Source files
------------

// File: rtl/psa_accum_pkg.sv
// -----------------------------------------------------------------------------
// psa_accum_pkg
// Shared EX-stage definitions for the nibble-lane accumulator:
//   - state_t    : burst FSM states (IDLE / ACCUM / HOLD)
//   - PSA_LANES  : number of independent signed lanes in an operand
//   - LANE_W     : width of one lane in bits
//   - DATA_W     : full operand width (PSA_LANES * LANE_W)
// -----------------------------------------------------------------------------
package psa_accum_pkg;

    localparam int PSA_LANES = 4;
    localparam int LANE_W    = 4;
    localparam int DATA_W    = PSA_LANES * LANE_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

endpackage : psa_accum_pkg

// File: rtl/psa_accum_if.sv
// -----------------------------------------------------------------------------
// psa_accum_if
// Operand input stream and result output stream of psa_accum.
//   in_valid / in_ready / in_data / in_last : operand beats, valid/ready
//   out_valid / out_ready                   : result handshake
//   out_sum / out_error / out_first_err / out_count : burst result
// Modports:
//   master : the environment (drives operands, consumes results)
//   slave  : the accumulator itself
// -----------------------------------------------------------------------------
interface psa_accum_if
    import psa_accum_pkg::*;
#(
    parameter int CNT_W = 4
) ();

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_sum;
    logic              out_error;
    logic [CNT_W-1:0]  out_first_err;
    logic [CNT_W-1:0]  out_count;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_error, out_first_err, out_count
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_error, out_first_err, out_count
    );

endinterface : psa_accum_if

// File: rtl/psa_accum_psa_16bit.sv
// -----------------------------------------------------------------------------
// psa_16bit
// Purely combinational partitioned adder: four independent 4-bit signed lanes,
// no carry between lanes, results wrap.
//   a, b  : operands (lane 0 = [3:0])
//   sum   : lane-wise wrapped sum
//   error : OR of all lane signed overflows
// -----------------------------------------------------------------------------
module psa_16bit
    import psa_accum_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] sum,
    output logic              error
);

    logic [PSA_LANES-1:0] w_lane_ovf;

    genvar gi;
    generate
        for (gi = 0; gi < PSA_LANES; gi++) begin : g_lane
            logic [LANE_W-1:0] w_a;
            logic [LANE_W-1:0] w_b;
            logic [LANE_W-1:0] w_s;

            assign w_a = a[gi*LANE_W +: LANE_W];
            assign w_b = b[gi*LANE_W +: LANE_W];
            assign w_s = w_a + w_b;
            assign sum[gi*LANE_W +: LANE_W] = w_s;

            // Signed overflow: operands agree in sign but the result does not.
            assign w_lane_ovf[gi] = (w_a[LANE_W-1] == w_b[LANE_W-1]) &&
                                    (w_s[LANE_W-1] != w_a[LANE_W-1]);
        end
    endgenerate

    assign error = |w_lane_ovf;

endmodule : psa_16bit

// File: rtl/psa_accum.sv
// -----------------------------------------------------------------------------
// psa_accum
// Sequential nibble-lane accumulator. Folds a burst of 16-bit operands into a
// running value through psa_16bit and holds the result with a sticky overflow
// flag, the index of the first overflowing beat and the beat count.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   rst_n : synchronous active-low reset
//   bus   : psa_accum_if.slave (operand stream in, result out)
// Parameters:
//   MAX_LEN : beats after which a burst closes on its own
//   CNT_W   : beat counter width, $clog2(MAX_LEN+1)
// -----------------------------------------------------------------------------
module psa_accum
    import psa_accum_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    psa_accum_if.slave  bus
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LEN);

    state_t            r_state;
    state_t            w_state_next;
    logic [DATA_W-1:0] r_acc;
    logic              r_err;
    logic [CNT_W-1:0]  r_first_err;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_accept;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic [DATA_W-1:0] w_psa_sum;
    logic              w_psa_err;

    psa_16bit iPSA (
        .a     (r_acc),
        .b     (bus.in_data),
        .sum   (w_psa_sum),
        .error (w_psa_err)
    );

    assign w_accept  = bus.in_valid && w_in_ready;
    assign w_cnt_inc = r_cnt + 1'b1;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    w_state_next = (bus.in_last || MAX_LEN == 1) ? ST_HOLD : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                // Reaching MAX_LEN closes the burst whether or not in_last is set.
                if (bus.in_valid) begin
                    w_state_next = (bus.in_last || w_cnt_inc == MAX_CNT) ? ST_HOLD : ST_ACCUM;
                end
            end
            ST_HOLD: begin
                if (bus.out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            ST_IDLE:  w_in_ready  = 1'b1;
            ST_ACCUM: w_in_ready  = 1'b1;
            ST_HOLD:  w_out_valid = 1'b1;
            default: begin
                w_in_ready  = 1'b0;
                w_out_valid = 1'b0;
            end
        endcase
    end

    // Datapath: only an accepted beat changes the accumulator registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_err       <= 1'b0;
            r_first_err <= '0;
            r_cnt       <= '0;
        end else if (w_accept) begin
            if (r_state == ST_IDLE) begin
                // First beat: adding to zero cannot overflow, so load directly.
                r_acc       <= bus.in_data;
                r_err       <= 1'b0;
                r_first_err <= '0;
                r_cnt       <= CNT_W'(1);
            end else begin
                r_acc <= w_psa_sum;
                r_cnt <= w_cnt_inc;
                // r_cnt is the 0-based index of the beat being folded in.
                if (w_psa_err && !r_err) begin
                    r_err       <= 1'b1;
                    r_first_err <= r_cnt;
                end
            end
        end
    end

    assign bus.in_ready      = w_in_ready;
    assign bus.out_valid     = w_out_valid;
    assign bus.out_sum       = r_acc;
    assign bus.out_error     = r_err;
    assign bus.out_first_err = r_first_err;
    assign bus.out_count     = r_cnt;

endmodule : psa_accum
